zynet_inference_sequencer: RTL and testbench

Sequences one complete inference through the zyNet datapath: it starts the network, streams one input frame, and collects the class scores. On a host request it pulses the network start, passes exactly one frame of input words through a valid/ready channel, then waits (with timeout) for the network's output vector. It consumes that vector, runs a serial signed argmax over the class scores, and presents the winning class and score to the host. It sits between the host/sample-buffer interface and the top-level network.

---
 rtl/zynet_inference_sequencer.sv | 141 ++++++++++++++
 tb/tb_zynet_inference_sequencer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zynet_inference_sequencer.sv
// Runs one zyNet inference: pulses the network start, forwards one input frame,
// waits (bounded) for the class scores and reduces them to a signed argmax result.
`timescale 1ns/1ps
module zynet_inference_sequencer #(
  parameter int WORD_SIZE      = 16,
  parameter int OUTPUT_SIZE    = 10,
  parameter int FRAME_WORDS    = 256,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CLASS_W        = $clog2(OUTPUT_SIZE)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             req_i,
  output logic                             busy_o,
  input  logic [WORD_SIZE-1:0]             host_data_i,
  input  logic                             host_valid_i,
  output logic                             host_ready_o,
  output logic                             net_start_o,
  output logic [WORD_SIZE-1:0]             net_data_o,
  output logic                             net_valid_o,
  input  logic                             net_ready_i,
  input  logic [OUTPUT_SIZE*WORD_SIZE-1:0] net_data_i,
  input  logic                             net_valid_i,
  output logic                             net_yumi_o,
  output logic [CLASS_W-1:0]               class_o,
  output logic [WORD_SIZE-1:0]             score_o,
  output logic                             error_o,
  output logic                             result_valid_o,
  input  logic                             result_yumi_i
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_ARGMAX = 3'd4;
  localparam logic [2:0] S_RESULT = 3'd5;

  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   LAST_WORD = CNT_W'(FRAME_WORDS - 1);
  localparam logic [TMO_W-1:0]   LAST_TMO  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CLASS_W-1:0] LAST_IDX  = CLASS_W'(OUTPUT_SIZE - 1);

  logic [2:0]                  r_state;
  logic [2:0]                  w_next_state;
  logic [CNT_W-1:0]            r_word_cnt;
  logic [TMO_W-1:0]            r_tmo_cnt;
  logic signed [WORD_SIZE-1:0] r_scores [OUTPUT_SIZE];
  logic signed [WORD_SIZE-1:0] r_best_score;
  logic [CLASS_W-1:0]          r_best_idx;
  logic [CLASS_W-1:0]          r_idx;
  logic                        r_error;

  logic                        w_handshake;
  logic                        w_last_word;
  logic                        w_timeout;
  logic signed [WORD_SIZE-1:0] w_cand;
  logic                        w_better;

  assign w_handshake = (r_state == S_STREAM) && host_valid_i && net_ready_i;
  assign w_last_word = (r_word_cnt == LAST_WORD);
  assign w_timeout   = (r_tmo_cnt == LAST_TMO);
  assign w_cand      = r_scores[r_idx];
  // Strictly greater keeps the lowest index on ties.
  assign w_better    = (w_cand > r_best_score);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (req_i) w_next_state = S_START;
      S_START:  w_next_state = S_STREAM;
      S_STREAM: if (w_handshake && w_last_word) w_next_state = S_WAIT;
      S_WAIT: begin
        if (net_valid_i)    w_next_state = S_ARGMAX;
        else if (w_timeout) w_next_state = S_RESULT;
      end
      S_ARGMAX: if (r_idx == LAST_IDX) w_next_state = S_RESULT;
      S_RESULT: if (result_yumi_i) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_word_cnt   <= '0;
      r_tmo_cnt    <= '0;
      r_best_score <= '0;
      r_best_idx   <= '0;
      r_idx        <= '0;
      r_error      <= 1'b0;
      for (int k = 0; k < OUTPUT_SIZE; k++) r_scores[k] <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_START: r_word_cnt <= '0;
        S_STREAM: begin
          if (w_handshake) r_word_cnt <= r_word_cnt + 1'b1;
          if (w_handshake && w_last_word) r_tmo_cnt <= '0;
        end
        S_WAIT: begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
          // A score vector arriving on the timeout cycle still wins.
          if (net_valid_i) begin
            for (int k = 0; k < OUTPUT_SIZE; k++)
              r_scores[k] <= net_data_i[k*WORD_SIZE +: WORD_SIZE];
            r_best_score <= net_data_i[WORD_SIZE-1:0];
            r_best_idx   <= '0;
            r_idx        <= CLASS_W'(1);
            r_error      <= 1'b0;
          end else if (w_timeout) begin
            r_best_score <= '0;
            r_best_idx   <= '0;
            r_error      <= 1'b1;
          end
        end
        S_ARGMAX: begin
          if (w_better) begin
            r_best_score <= w_cand;
            r_best_idx   <= r_idx;
          end
          r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy_o         = (r_state != S_IDLE);
  assign net_start_o    = (r_state == S_START);
  assign net_data_o     = host_data_i;
  assign net_valid_o    = (r_state == S_STREAM) && host_valid_i;
  assign host_ready_o   = (r_state == S_STREAM) && net_ready_i;
  assign net_yumi_o     = (r_state == S_WAIT) && net_valid_i;
  assign result_valid_o = (r_state == S_RESULT);
  assign class_o        = r_best_idx;
  assign score_o        = r_best_score;
  assign error_o        = r_error;

endmodule

// File: tb/tb_zynet_inference_sequencer.sv
// Directed bench for zynet_inference_sequencer: frame streaming, signed argmax,
// timeout and its boundary, mid-frame reset, result hold and back-to-back requests.
`timescale 1ns/1ps
module tb_zynet_inference_sequencer;
  localparam int W = 16, N = 10, FW = 256, TMO = 20, CW = 4;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1, req_i = 1'b0;
  logic          busy_o;
  logic [W-1:0]  host_data_i = '0;
  logic          host_valid_i = 1'b0, host_ready_o;
  logic          net_start_o;
  logic [W-1:0]  net_data_o;
  logic          net_valid_o, net_ready_i = 1'b0;
  logic [N*W-1:0] net_data_i = '0;
  logic          net_valid_i = 1'b0, net_yumi_o;
  logic [CW-1:0] class_o;
  logic [W-1:0]  score_o;
  logic          error_o, result_valid_o, result_yumi_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  zynet_inference_sequencer #(
    .WORD_SIZE(W), .OUTPUT_SIZE(N), .FRAME_WORDS(FW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .busy_o(busy_o),
    .host_data_i(host_data_i), .host_valid_i(host_valid_i), .host_ready_o(host_ready_o),
    .net_start_o(net_start_o), .net_data_o(net_data_o), .net_valid_o(net_valid_o),
    .net_ready_i(net_ready_i), .net_data_i(net_data_i), .net_valid_i(net_valid_i),
    .net_yumi_o(net_yumi_o), .class_o(class_o), .score_o(score_o), .error_o(error_o),
    .result_valid_o(result_valid_o), .result_yumi_i(result_yumi_i)
  );

  function automatic logic [N*W-1:0] pack(input int sc[N]);
    logic [N*W-1:0] p;
    p = '0;
    for (int k = 0; k < N; k++) p[k*W +: W] = W'(sc[k]);
    return p;
  endfunction

  // Leaves the bench 1 time unit into the START cycle.
  task automatic do_req();
    req_i = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b0;
  endtask

  // Drives n host words (optionally with random stalls) starting in the first STREAM cycle.
  task automatic stream_words(input int n, input bit stall, input int base,
                              output int sent, output int cycles, output int err);
    sent = 0; cycles = 0; err = 0;
    @(posedge clk); #1;
    while (sent < n && cycles < 4000) begin
      host_valid_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      net_ready_i  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      host_data_i  = W'(base + sent);
      #1;
      if (net_valid_o !== host_valid_i || net_start_o !== 1'b0) err++;
      if (net_ready_i && !host_ready_o) break;
      if (host_valid_i && net_ready_i) begin
        if (net_data_o !== host_data_i) err++;
        sent++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    host_valid_i = 1'b0;
    net_ready_i  = 1'b0;
  endtask

  task automatic probe_wait(output logic hr, output logic nv, output logic bz);
    host_valid_i = 1'b1; net_ready_i = 1'b1;
    #1;
    hr = host_ready_o; nv = net_valid_o; bz = busy_o;
    host_valid_i = 1'b0; net_ready_i = 1'b0;
  endtask

  // Presents scores for 'hold' cycles, then waits for RESULT; lat counts from the first valid cycle.
  task automatic deliver(input int sc[N], input int hold, output int yumis, output int lat);
    yumis = 0; lat = 0;
    net_data_i  = pack(sc);
    net_valid_i = 1'b1;
    for (int h = 0; h < hold; h++) begin
      #1;
      if (net_yumi_o) yumis++;
      @(posedge clk); #1;
      lat++;
    end
    net_valid_i = 1'b0;
    while (!result_valid_o && lat < 100) begin
      if (net_yumi_o) yumis++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    result_yumi_i = 1'b1;
    @(posedge clk); #1;
    result_yumi_i = 1'b0;
  endtask

  task automatic test_reset();
    host_valid_i = 1'b1; net_ready_i = 1'b1; net_valid_i = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if ({busy_o, net_start_o, net_valid_o, host_ready_o, net_yumi_o, result_valid_o, error_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0000000", {busy_o, net_start_o, net_valid_o, host_ready_o, net_yumi_o, result_valid_o, error_o});
    end
    n_checks++;
    if (class_o !== '0 || score_o !== '0) begin
      n_fail++;
      $display("FAIL reset_result: class %0d score %0d required 0 0", class_o, score_o);
    end
    host_valid_i = 1'b0; net_ready_i = 1'b0; net_valid_i = 1'b0;
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    int sent, cyc, err, yumis, lat;
    logic hr, nv, bz;
    int sc[N];
    sc = '{-3, 5, 2, 5, 1, 0, -1, 4, 3, 0};
    do_req();
    n_checks++;
    if (net_start_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL nom_start: start %0d busy %0d required 1 1", net_start_o, busy_o);
    end
    stream_words(FW, 1'b0, 16'h1000, sent, cyc, err);
    n_checks++;
    if (sent !== FW || cyc !== FW) begin
      n_fail++;
      $display("FAIL nom_stream_count: words %0d cycles %0d required %0d %0d", sent, cyc, FW, FW);
    end
    n_checks++;
    if (err !== 0) begin n_fail++; $display("FAIL nom_stream_data: errors %0d required 0", err); end
    probe_wait(hr, nv, bz);
    n_checks++;
    if ({hr, nv, bz} !== 3'b001) begin
      n_fail++;
      $display("FAIL nom_wait_entry: ready/valid/busy %b required 001", {hr, nv, bz});
    end
    deliver(sc, 3, yumis, lat);
    n_checks++;
    if (yumis !== 1) begin n_fail++; $display("FAIL nom_yumi_pulses: got %0d required 1", yumis); end
    n_checks++;
    if (lat !== 10) begin n_fail++; $display("FAIL nom_latency: got %0d required 10", lat); end
    n_checks++;
    if (class_o !== 4'd1 || $signed(score_o) !== 16'sd5 || error_o !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_result: class %0d score %0d err %0d required 1 5 0", class_o, $signed(score_o), error_o);
    end
    consume();
    n_checks++;
    if (result_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_release: valid %0d busy %0d required 0 0", result_valid_o, busy_o);
    end
  endtask

  task automatic test_reset_midstream();
    int sent, cyc, err, yumis, lat;
    logic hr, nv, bz;
    int sc[N];
    sc = '{1, 2, 3, 4, 6, 5, 0, -1, 6, 2};
    do_req();
    stream_words(100, 1'b0, 0, sent, cyc, err);
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    host_valid_i = 1'b1; net_ready_i = 1'b1; net_valid_i = 1'b1;
    #1;
    n_checks++;
    if ({busy_o, net_start_o, net_valid_o, host_ready_o, net_yumi_o, result_valid_o, error_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL rst_mid_ctrl: got %b required 0000000", {busy_o, net_start_o, net_valid_o, host_ready_o, net_yumi_o, result_valid_o, error_o});
    end
    n_checks++;
    if (class_o !== '0 || score_o !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_result: class %0d score %0d required 0 0", class_o, score_o);
    end
    host_valid_i = 1'b0; net_ready_i = 1'b0; net_valid_i = 1'b0;
    @(posedge clk); #1;
    do_req();
    stream_words(FW, 1'b0, 16'h2000, sent, cyc, err);
    n_checks++;
    if (sent !== FW || err !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_frame: words %0d errors %0d required %0d 0", sent, err, FW);
    end
    probe_wait(hr, nv, bz);
    n_checks++;
    if ({hr, nv, bz} !== 3'b001) begin
      n_fail++;
      $display("FAIL rst_mid_wait: ready/valid/busy %b required 001", {hr, nv, bz});
    end
    deliver(sc, 1, yumis, lat);
    n_checks++;
    if (class_o !== 4'd4 || $signed(score_o) !== 16'sd6 || error_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_result2: class %0d score %0d err %0d required 4 6 0", class_o, $signed(score_o), error_o);
    end
    consume();
  endtask

  task automatic test_random_stalls();
    int sent, cyc, err, yumis, lat;
    logic hr, nv, bz;
    int sc[N];
    sc = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    do_req();
    stream_words(FW, 1'b1, 16'h3000, sent, cyc, err);
    n_checks++;
    if (sent !== FW) begin n_fail++; $display("FAIL stall_count: words %0d required %0d", sent, FW); end
    n_checks++;
    if (err !== 0) begin n_fail++; $display("FAIL stall_data: errors %0d required 0", err); end
    probe_wait(hr, nv, bz);
    n_checks++;
    if ({hr, nv, bz} !== 3'b001) begin
      n_fail++;
      $display("FAIL stall_wait_entry: ready/valid/busy %b required 001", {hr, nv, bz});
    end
    deliver(sc, 1, yumis, lat);
    n_checks++;
    if (class_o !== 4'd7 || $signed(score_o) !== 16'sd1) begin
      n_fail++;
      $display("FAIL stall_result: class %0d score %0d required 7 1", class_o, $signed(score_o));
    end
    consume();
  endtask

  task automatic test_signed_argmax();
    int sent, cyc, err, yumis, lat;
    logic hr, nv, bz;
    int sc[N];
    sc = '{-8, -2, -5, -9, -3, -7, -4, -6, -10, -11};
    do_req();
    stream_words(FW, 1'b0, 0, sent, cyc, err);
    probe_wait(hr, nv, bz);
    deliver(sc, 1, yumis, lat);
    n_checks++;
    if (class_o !== 4'd1 || $signed(score_o) !== -16'sd2 || lat !== 10) begin
      n_fail++;
      $display("FAIL neg_result: class %0d score %0d lat %0d required 1 -2 10", class_o, $signed(score_o), lat);
    end
    consume();
    sc = '{-32768, 3, 32766, -1, 32766, 0, 7, -5, 100, 32767};
    do_req();
    stream_words(FW, 1'b0, 0, sent, cyc, err);
    probe_wait(hr, nv, bz);
    deliver(sc, 1, yumis, lat);
    n_checks++;
    if (class_o !== 4'd9 || $signed(score_o) !== 16'sd32767 || lat !== 10) begin
      n_fail++;
      $display("FAIL last_idx_result: class %0d score %0d lat %0d required 9 32767 10", class_o, $signed(score_o), lat);
    end
    consume();
  endtask

  task automatic test_timeout();
    int sent, cyc, err, yumis, lat, w;
    logic hr, nv, bz;
    int sc[N];
    do_req();
    stream_words(FW, 1'b0, 0, sent, cyc, err);
    probe_wait(hr, nv, bz);
    w = 0;
    while (!result_valid_o && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    n_checks++;
    if (w !== TMO) begin n_fail++; $display("FAIL timeout_cycles: got %0d required %0d", w, TMO); end
    n_checks++;
    if (error_o !== 1'b1 || class_o !== '0 || score_o !== '0) begin
      n_fail++;
      $display("FAIL timeout_result: err %0d class %0d score %0d required 1 0 0", error_o, class_o, score_o);
    end
    consume();
    // Scores arriving in the last WAIT cycle must beat the timeout.
    sc = '{7, -4, 7, 0, 12, 3, 12, -100, 1, 2};
    do_req();
    stream_words(FW, 1'b0, 0, sent, cyc, err);
    probe_wait(hr, nv, bz);
    repeat (TMO - 1) @(posedge clk);
    #1;
    n_checks++;
    if (result_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_boundary_early: valid %0d busy %0d required 0 1", result_valid_o, busy_o);
    end
    deliver(sc, 1, yumis, lat);
    n_checks++;
    if (yumis !== 1 || lat !== 10) begin
      n_fail++;
      $display("FAIL tmo_boundary_timing: yumi %0d lat %0d required 1 10", yumis, lat);
    end
    n_checks++;
    if (error_o !== 1'b0 || class_o !== 4'd4 || $signed(score_o) !== 16'sd12) begin
      n_fail++;
      $display("FAIL tmo_boundary_result: err %0d class %0d score %0d required 0 4 12", error_o, class_o, $signed(score_o));
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int sent, cyc, err, yumis, lat, unstable, starts;
    logic hr, nv, bz;
    int sc[N];
    sc = '{0, -5, 3, 11, -2, 11, 4, -7, 10, 1};
    do_req();
    stream_words(FW, 1'b0, 0, sent, cyc, err);
    probe_wait(hr, nv, bz);
    deliver(sc, 1, yumis, lat);
    unstable = 0; starts = 0;
    for (int i = 0; i < 50; i++) begin
      req_i = (i % 7 == 0);
      #1;
      if (result_valid_o !== 1'b1 || class_o !== 4'd3 || $signed(score_o) !== 16'sd11 || error_o !== 1'b0) unstable++;
      if (net_start_o) starts++;
      @(posedge clk); #1;
    end
    req_i = 1'b0;
    n_checks++;
    if (unstable !== 0) begin n_fail++; $display("FAIL hold_stable: unstable cycles %0d required 0", unstable); end
    n_checks++;
    if (starts !== 0) begin n_fail++; $display("FAIL hold_req_ignored: starts %0d required 0", starts); end
    result_yumi_i = 1'b1; req_i = 1'b1;
    @(posedge clk); #1;
    result_yumi_i = 1'b0; req_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy_o !== 1'b0 || net_start_o !== 1'b0 || result_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_not_queued: busy %0d start %0d valid %0d required 0 0 0", busy_o, net_start_o, result_valid_o);
    end
    sc = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
    do_req();
    stream_words(FW, 1'b0, 0, sent, cyc, err);
    probe_wait(hr, nv, bz);
    deliver(sc, 1, yumis, lat);
    n_checks++;
    if (class_o !== 4'd0 || $signed(score_o) !== -16'sd1) begin
      n_fail++;
      $display("FAIL tie_all_equal: class %0d score %0d required 0 -1", class_o, $signed(score_o));
    end
    result_yumi_i = 1'b1; req_i = 1'b1;
    @(posedge clk); #1;
    result_yumi_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy %0d required 0", busy_o); end
    @(posedge clk); #1;
    req_i = 1'b0;
    n_checks++;
    if (net_start_o !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: start %0d required 1", net_start_o); end
    sc = '{2, 4, 8, 16, 32, 64, 128, 256, 512, 511};
    stream_words(FW, 1'b0, 16'h4000, sent, cyc, err);
    n_checks++;
    if (sent !== FW || err !== 0) begin
      n_fail++;
      $display("FAIL b2b_frame: words %0d errors %0d required %0d 0", sent, err, FW);
    end
    probe_wait(hr, nv, bz);
    deliver(sc, 1, yumis, lat);
    n_checks++;
    if (class_o !== 4'd8 || $signed(score_o) !== 16'sd512 || error_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_result: class %0d score %0d err %0d required 8 512 0", class_o, $signed(score_o), error_o);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_reset_midstream();
    test_random_stalls();
    test_signed_argmax();
    test_timeout();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
